// File: rtl/area_frame_accum_if.sv
// Stream bundle between the triangle-area stage, the frame accumulator and its consumer.
// The slave modport is the accumulator's view; master is the producer/consumer side.
interface area_frame_accum_if #(
  parameter int unsigned AREA_W = 26,
  parameter int unsigned ACC_W  = 32
) ();

  logic signed [AREA_W-1:0] area;
  logic                     area_vld;
  logic        [ACC_W-1:0]  sum_out;
  logic                     sum_vld;
  logic                     sum_rdy;
  logic                     sum_sat;

  modport slave (
    input  area,
    input  area_vld,
    input  sum_rdy,
    output sum_out,
    output sum_vld,
    output sum_sat
  );

  modport master (
    output area,
    output area_vld,
    output sum_rdy,
    input  sum_out,
    input  sum_vld,
    input  sum_sat
  );

endinterface

// File: rtl/area_frame_accum.sv
// Sums SAMPLES_PER_FRAME clamped segment areas into a saturating frame total and
// hands it to a one-deep valid/ready output register; counts frames and flags drops.
module area_frame_accum #(
  parameter int unsigned SAMPLES_PER_FRAME = 64,
  parameter int unsigned AREA_W            = 26,
  parameter int unsigned ACC_W             = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  area_frame_accum_if.slave    bus,
  output logic [15:0]          frame_cnt,
  output logic                 ovf_err
);

  localparam int unsigned CNT_W = (SAMPLES_PER_FRAME > 2) ? $clog2(SAMPLES_PER_FRAME) : 1;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(SAMPLES_PER_FRAME - 1);

  // Accumulation phase is implied by the sample counter.
  localparam logic [0:0] StAccum = 1'b0;
  localparam logic [0:0] StLast  = 1'b1;

  // Output register occupancy, carried by sum_vld.
  localparam logic [0:0] StEmpty = 1'b0;
  localparam logic [0:0] StFull  = 1'b1;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_sat_q, acc_sat_d;
  logic [ACC_W-1:0] sum_out_q, sum_out_d;
  logic             sum_vld_q, sum_vld_d;
  logic             sum_sat_q, sum_sat_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             ovf_err_q, ovf_err_d;

  logic [0:0]       phase;
  logic [0:0]       out_state;
  logic [ACC_W-1:0] area_cond;
  logic [ACC_W:0]   nxt_wide;
  logic             sat_now;
  logic [ACC_W-1:0] nxt;
  logic             accept;
  logic             complete;
  logic             out_free;
  logic             total_sat;

  assign phase     = (cnt_q == LastCnt) ? StLast : StAccum;
  assign out_state = sum_vld_q ? StFull : StEmpty;

  // Negative areas contribute nothing but still occupy a sample slot.
  assign area_cond = bus.area[AREA_W-1] ? '0 : ACC_W'($unsigned(bus.area));
  assign nxt_wide  = {1'b0, acc_q} + {1'b0, area_cond};
  assign sat_now   = nxt_wide[ACC_W];
  assign nxt       = sat_now ? '1 : nxt_wide[ACC_W-1:0];

  assign accept    = bus.area_vld & ~clr;
  assign complete  = accept & (phase == StLast);
  assign out_free  = (out_state == StEmpty) | bus.sum_rdy;
  assign total_sat = acc_sat_q | sat_now;

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    acc_sat_d = acc_sat_q;
    if (clr) begin
      acc_d     = '0;
      cnt_d     = '0;
      acc_sat_d = 1'b0;
    end else if (bus.area_vld) begin
      if (phase == StLast) begin
        acc_d     = '0;
        cnt_d     = '0;
        acc_sat_d = 1'b0;
      end else begin
        acc_d     = nxt;
        cnt_d     = cnt_q + 1'b1;
        acc_sat_d = total_sat;
      end
    end
  end

  always_comb begin
    sum_out_d   = sum_out_q;
    sum_vld_d   = sum_vld_q;
    sum_sat_d   = sum_sat_q;
    frame_cnt_d = frame_cnt_q;
    ovf_err_d   = ovf_err_q;
    if (complete && out_free) begin
      sum_out_d   = nxt;
      sum_sat_d   = total_sat;
      sum_vld_d   = 1'b1;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else if ((out_state == StFull) && bus.sum_rdy) begin
      sum_vld_d = 1'b0;
    end
    // A finished frame with nowhere to go is lost; remember that until reset.
    if (complete && !out_free) begin
      ovf_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      acc_sat_q   <= 1'b0;
      sum_out_q   <= '0;
      sum_vld_q   <= 1'b0;
      sum_sat_q   <= 1'b0;
      frame_cnt_q <= '0;
      ovf_err_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      acc_sat_q   <= acc_sat_d;
      sum_out_q   <= sum_out_d;
      sum_vld_q   <= sum_vld_d;
      sum_sat_q   <= sum_sat_d;
      frame_cnt_q <= frame_cnt_d;
      ovf_err_q   <= ovf_err_d;
    end
  end

  assign bus.sum_out = sum_out_q;
  assign bus.sum_vld = sum_vld_q;
  assign bus.sum_sat = sum_sat_q;
  assign frame_cnt   = frame_cnt_q;
  assign ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_area_frame_accum.sv
// Bench for area_frame_accum: directed table, corner sequences and random traffic on two
// configurations (N=4/ACC_W=32 and N=8/ACC_W=27) against a frame-level reference model.
module tb_area_frame_accum;

  logic        clk;
  logic        rst;
  logic        clr_a, clr_b;
  logic [15:0] fcnt_a, fcnt_b;
  logic        ovf_a, ovf_b;

  area_frame_accum_if #(.AREA_W(26), .ACC_W(32)) if_a ();
  area_frame_accum_if #(.AREA_W(26), .ACC_W(27)) if_b ();

  area_frame_accum #(.SAMPLES_PER_FRAME(4), .AREA_W(26), .ACC_W(32)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_a),
    .bus       (if_a),
    .frame_cnt (fcnt_a),
    .ovf_err   (ovf_a)
  );

  area_frame_accum #(.SAMPLES_PER_FRAME(8), .AREA_W(26), .ACC_W(27)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_b),
    .bus       (if_b),
    .frame_cnt (fcnt_b),
    .ovf_err   (ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus for the next cycle, per DUT.
  bit     in_clr[2];
  bit     in_vld[2];
  longint in_area[2];
  bit     in_rdy[2];

  // Frame-level reference: raw (unsaturated) sum of clamped samples and a sample count.
  int     m_cnt[2];
  longint m_raw[2];
  longint m_sum[2];
  bit     m_vld[2];
  bit     m_sat[2];
  int     m_fcnt[2];
  bit     m_ovf[2];

  function automatic int n_of(int d);
    return (d == 0) ? 4 : 8;
  endfunction

  function automatic longint max_of(int d);
    return (d == 0) ? ((64'sd1 <<< 32) - 1) : ((64'sd1 <<< 27) - 1);
  endfunction

  task automatic model_step(int d);
    bit     done;
    bit     free;
    longint tot;
    done = 1'b0;
    tot  = 0;
    if (!rst) begin
      m_cnt[d] = 0; m_raw[d] = 0; m_sum[d] = 0; m_vld[d] = 0;
      m_sat[d] = 0; m_fcnt[d] = 0; m_ovf[d] = 0;
      return;
    end
    free = !m_vld[d] || in_rdy[d];
    if (in_clr[d]) begin
      m_cnt[d] = 0;
      m_raw[d] = 0;
    end else if (in_vld[d]) begin
      m_raw[d] += (in_area[d] < 0) ? 0 : in_area[d];
      m_cnt[d]++;
      if (m_cnt[d] == n_of(d)) begin
        done     = 1'b1;
        tot      = m_raw[d];
        m_cnt[d] = 0;
        m_raw[d] = 0;
      end
    end
    if (done && free) begin
      m_sum[d]  = (tot > max_of(d)) ? max_of(d) : tot;
      m_sat[d]  = (tot > max_of(d));
      m_vld[d]  = 1'b1;
      m_fcnt[d] = (m_fcnt[d] + 1) % 65536;
    end else if (m_vld[d] && in_rdy[d]) begin
      m_vld[d] = 1'b0;
    end
    if (done && !free) m_ovf[d] = 1'b1;
  endtask

  task automatic check(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_out(int d, string tag, bit ev, longint esum, bit esat, int efc, bit eovf);
    if (d == 0) begin
      check({tag, " a.sum_vld"}, longint'(if_a.sum_vld), longint'(ev));
      check({tag, " a.sum_out"}, longint'(if_a.sum_out), esum);
      check({tag, " a.sum_sat"}, longint'(if_a.sum_sat), longint'(esat));
      check({tag, " a.frame_cnt"}, longint'(fcnt_a), longint'(efc));
      check({tag, " a.ovf_err"}, longint'(ovf_a), longint'(eovf));
    end else begin
      check({tag, " b.sum_vld"}, longint'(if_b.sum_vld), longint'(ev));
      check({tag, " b.sum_out"}, longint'(if_b.sum_out), esum);
      check({tag, " b.sum_sat"}, longint'(if_b.sum_sat), longint'(esat));
      check({tag, " b.frame_cnt"}, longint'(fcnt_b), longint'(efc));
      check({tag, " b.ovf_err"}, longint'(ovf_b), longint'(eovf));
    end
  endtask

  task automatic drive(int d, bit c, bit v, longint a, bit r);
    in_clr[d]  = c;
    in_vld[d]  = v;
    in_area[d] = a;
    in_rdy[d]  = r;
  endtask

  task automatic step();
    logic [63:0] wa;
    logic [63:0] wb;
    wa = in_area[0];
    wb = in_area[1];
    clr_a = in_clr[0]; if_a.area_vld = in_vld[0]; if_a.area = wa[25:0]; if_a.sum_rdy = in_rdy[0];
    clr_b = in_clr[1]; if_b.area_vld = in_vld[1]; if_b.area = wb[25:0]; if_b.sum_rdy = in_rdy[1];
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      expect_out(d, "model", m_vld[d], m_sum[d], m_sat[d], m_fcnt[d], m_ovf[d]);
    end
  endtask

  typedef struct {
    bit     clr;
    bit     vld;
    int     area;
    bit     rdy;
    bit     ev;
    longint esum;
    bit     esat;
    int     efc;
    bit     eovf;
  } vec_t;

  vec_t tbl[20];

  initial begin
    // Directed vectors for DUT a (N=4): normal frame, overflow drop, negative clamp.
    tbl[0]  = '{0, 1,  100, 1, 0,    0, 0, 0, 0};
    tbl[1]  = '{0, 1,  200, 1, 0,    0, 0, 0, 0};
    tbl[2]  = '{0, 1,  300, 1, 0,    0, 0, 0, 0};
    tbl[3]  = '{0, 1,  400, 1, 1, 1000, 0, 1, 0};
    tbl[4]  = '{0, 0,    0, 1, 0, 1000, 0, 1, 0};
    tbl[5]  = '{0, 1,    1, 0, 0, 1000, 0, 1, 0};
    tbl[6]  = '{0, 1,    2, 0, 0, 1000, 0, 1, 0};
    tbl[7]  = '{0, 1,    3, 0, 0, 1000, 0, 1, 0};
    tbl[8]  = '{0, 1,    4, 0, 1,   10, 0, 2, 0};
    tbl[9]  = '{0, 1,   10, 0, 1,   10, 0, 2, 0};
    tbl[10] = '{0, 1,   20, 0, 1,   10, 0, 2, 0};
    tbl[11] = '{0, 1,   30, 0, 1,   10, 0, 2, 0};
    tbl[12] = '{0, 1,   40, 0, 1,   10, 0, 2, 1};
    tbl[13] = '{0, 0,    0, 1, 0,   10, 0, 2, 1};
    tbl[14] = '{0, 0,    0, 0, 0,   10, 0, 2, 1};
    tbl[15] = '{0, 1,   -5, 1, 0,   10, 0, 2, 1};
    tbl[16] = '{0, 1,   10, 1, 0,   10, 0, 2, 1};
    tbl[17] = '{0, 1,   -1, 1, 0,   10, 0, 2, 1};
    tbl[18] = '{0, 1,   20, 1, 1,   30, 0, 3, 1};
    tbl[19] = '{0, 0,    0, 1, 0,   30, 0, 3, 1};

    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    rst = 1'b0;
    step();
    step();
    expect_out(0, "reset", 0, 0, 0, 0, 0);
    expect_out(1, "reset", 0, 0, 0, 0, 0);
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(0, tbl[i].clr, tbl[i].vld, tbl[i].area, tbl[i].rdy);
      drive(1, 0, 0, 0, 1);
      step();
      expect_out(0, $sformatf("tbl%0d", i), tbl[i].ev, tbl[i].esum, tbl[i].esat,
                 tbl[i].efc, tbl[i].eovf);
    end

    // Saturation on DUT b (ACC_W=27), then a clean frame clears the flag.
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 1, 33554431, 1);
      step();
    end
    expect_out(1, "sat", 1, 134217727, 1, 1, 0);
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 1, 1, 1);
      step();
    end
    expect_out(1, "nosat", 1, 8, 0, 2, 0);
    drive(1, 0, 0, 0, 1);

    // Abort mid-frame with a coincident sample, then on a would-be last sample.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2 + k; i++) begin
        drive(0, 0, 1, 7, 1);
        step();
      end
      drive(0, 1, 1, 7, 1);
      step();
      check($sformatf("clr%0d no frame", k), longint'(if_a.sum_vld), 0);
      for (int i = 1; i <= 4; i++) begin
        drive(0, 0, 1, i, 1);
        step();
        if (i < 4) check($sformatf("clr%0d early vld", k), longint'(if_a.sum_vld), 0);
      end
      expect_out(0, $sformatf("clr%0d", k), 1, 10, 0, 4 + k, 1);
    end

    // Reset in the middle of a frame discards everything.
    drive(0, 0, 1, 9, 1);
    step();
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 1);
    step();
    expect_out(0, "midrst", 0, 0, 0, 0, 0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 5, 1);
      step();
    end
    expect_out(0, "postrst", 1, 20, 0, 1, 0);

    // Random traffic on both configurations.
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 2; d++) begin
        int     mode;
        longint a;
        mode = int'($urandom_range(0, 3));
        case (mode)
          0:       a = -longint'($urandom_range(1, 33554432));
          1:       a = 33554431 - longint'($urandom_range(0, 1000));
          default: a = longint'($urandom & 32'h01FF_FFFF);
        endcase
        drive(d, ($urandom_range(0, 31) == 0), ($urandom_range(0, 9) < 7), a,
              ($urandom_range(0, 1) == 1));
      end
      rst = ($urandom_range(0, 499) != 0);
      step();
    end
    rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/area_frame_accum.md
Name: area_frame_accum

Overview:
- Downstream consumer of the triangle-area stage.
- Accepts one area value per valid pulse from that stage: area in, rdy used as valid.
- Sums a fixed number of consecutive segment areas (one scan frame) into a saturating accumulator and presents the frame total on a one-deep valid/ready output register.
- Reports frame count, saturation and dropped-frame errors.

Parameters:
- SAMPLES_PER_FRAME, 64: number of area samples summed per frame; legal range 2..65535.
- AREA_W, 26: width of signed input area.
- ACC_W, 32: width of unsigned accumulator and sum output; must be >= AREA_W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low; clears all state when 0 at a rising edge.
- clr  in  1  synchronous frame abort; zeroes accumulator and sample counter; does not touch output register, frame_cnt or ovf_err.
- area  in  AREA_W  signed segment area from upstream stage.
- area_vld  in  1  one-cycle qualifier for area (driven by upstream rdy); no backpressure to upstream.
- sum_out  out  ACC_W  frame total, held stable while sum_vld=1.
- sum_vld  out  1  frame total valid.
- sum_rdy  in  1  consumer accepts sum_out when sum_vld & sum_rdy.
- sum_sat  out  1  frame total was saturated; qualified by sum_vld.
- frame_cnt  out  16  count of frames loaded into output register; wraps 65535->0.
- ovf_err  out  1  sticky: a completed frame was dropped because the output register was occupied.

Behaviour:
- Reset (rst=0): acc=0, cnt=0, sum_out=0, sum_vld=0, sum_sat=0, frame_cnt=0, ovf_err=0, acc_sat=0.
- Input conditioning: negative area is clamped to 0 before accumulation and still counts as a sample. Non-negative area is zero-extended to ACC_W.
- Accept, when area_vld=1 and clr=0:
  - nxt = acc + conditioned area, computed in ACC_W+1 bits.
  - If nxt >= 2^ACC_W, nxt = 2^ACC_W-1 and acc_sat is set for the frame.
  - If cnt != SAMPLES_PER_FRAME-1: acc=nxt, cnt=cnt+1.
  - If cnt == SAMPLES_PER_FRAME-1 (frame complete): acc=0, cnt=0, acc_sat=0, and the completion is offered to the output register with total nxt and sat flag (acc_sat | saturation this cycle).
- Output register, evaluated in the completion cycle:
  - Register is free when sum_vld=0, or when sum_vld & sum_rdy in that same cycle.
  - Free: next cycle sum_out=total, sum_sat=flag, sum_vld=1, frame_cnt+=1. Latency: sum_vld rises the cycle after the last sample's area_vld.
  - Occupied: the total is dropped; sum_out, sum_sat and frame_cnt are unchanged; ovf_err=1 until reset.
- Handshake:
  - sum_vld & sum_rdy with no completion in the same cycle: sum_vld=0 next cycle; sum_out holds its last value.
  - sum_vld must not drop without a handshake; sum_out must not change while sum_vld=1 and not accepted.
- clr=1: acc=0, cnt=0, acc_sat=0 next cycle. A coincident area_vld sample is discarded (clr wins), including on a would-be last sample.
- Single FSM, state implied by cnt: ACCUM (cnt 0..N-2) and LAST (cnt=N-1). Output register is a separate EMPTY/FULL flag (sum_vld).
- Back-to-back area_vld every cycle is supported; sustained throughput is one sample per clock.
- rst=0 mid-frame discards the partial sum and any pending output.

Test Plan:
- N=4, ACC_W=32, sum_rdy=1; area 100,200,300,400 on consecutive cycles -> sum_vld=1 for one cycle, starting one cycle after the 400 sample; sum_out=1000, sum_sat=0, frame_cnt=1.
- N=4, sum_rdy=0; frame 1,2,3,4 then frame 10,20,30,40 -> sum_out stays 10, frame_cnt=1, ovf_err=1. Then sum_rdy=1 -> sum_vld falls next cycle; ovf_err stays 1.
- N=8, AREA_W=26, ACC_W=27; eight samples of 33554431 -> sum_out=134217727, sum_sat=1. The following frame of eight 1s -> sum_out=8, sum_sat=0.
- N=4; area -5,10,-1,20 -> sum_out=30.
- N=4; samples 7,7 then clr=1 with coincident area_vld=1 (value 7), then 1,2,3,4 -> sum_out=10; no frame emitted from the aborted samples.
- N=4; two samples, then rst=0 for one cycle, then 5,5,5,5 -> all outputs 0 during reset, then sum_out=20, frame_cnt=1.
